// File: rtl/cai_submit_tracker.sv
// cai_submit_tracker
//   Host-side bookkeeping for the CAI submit and completion rings. It hands the host the
//   next free submit slot and sends one doorbell pulse per accepted submit. It counts
//   completion doorbells and presents completion slots in order until the host acks them.
//   It also flags spurious completions and, optionally, a stalled-completion timeout.
//
// Optional feature macro: CAI_SUBMIT_TIMEOUT_EN
//   Defined  : a watchdog counter drives the sticky 'timeout' flag.
//   Undefined: no watchdog counter is built and 'timeout' is tied to 0.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   slot_idx          submit-ring slot for the host's next descriptor
//   submit_valid      host has written the descriptor at slot_idx
//   submit_ready      at least one ring slot is free
//   submit_doorbell   one-cycle pulse per accepted submit (registered)
//   submit_ring_mask  constant RING_ENTRIES-1
//   comp_doorbell     accelerator completion pulse, one record per high cycle
//   comp_valid        an unacknowledged completion record exists
//   comp_idx          completion-ring slot to read
//   comp_ack          host has consumed the record at comp_idx
//   inflight          submitted but not yet completed
//   pending           completed but not yet acknowledged
//   err_spurious      sticky: completion doorbell with nothing in flight
//   timeout           sticky watchdog flag
//   err_clr           clears the sticky flags (a new error in the same cycle wins)
module cai_submit_tracker #(
  parameter int unsigned RING_ENTRIES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned IDX_W          = $clog2(RING_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] slot_idx,
  input  logic             submit_valid,
  output logic             submit_ready,
  output logic             submit_doorbell,
  output logic [31:0]      submit_ring_mask,
  input  logic             comp_doorbell,
  output logic             comp_valid,
  output logic [IDX_W-1:0] comp_idx,
  input  logic             comp_ack,
  output logic [IDX_W:0]   inflight,
  output logic [IDX_W:0]   pending,
  output logic             err_spurious,
  output logic             timeout,
  input  logic             err_clr
);

  localparam int unsigned CntW = IDX_W + 1;

  logic [IDX_W-1:0] prod_q, prod_d;
  logic [IDX_W-1:0] cons_q, cons_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic [CntW-1:0]  pending_q, pending_d;
  logic             doorbell_q, doorbell_d;
  logic             err_q, err_d;

  logic             sub_acc;
  logic             comp_acc;
  logic             ack_acc;
  logic [CntW:0]    occupancy;

  // Occupancy uses registered counts only, so an ack frees a slot one cycle later.
  assign occupancy    = {1'b0, inflight_q} + {1'b0, pending_q};
  assign submit_ready = (occupancy != (CntW + 1)'(RING_ENTRIES));

  assign sub_acc  = submit_valid && submit_ready;
  assign comp_acc = comp_doorbell && (inflight_q != '0);
  assign ack_acc  = comp_ack && (pending_q != '0);

  always_comb begin
    prod_d     = prod_q;
    cons_d     = cons_q;
    inflight_d = inflight_q + CntW'(sub_acc) - CntW'(comp_acc);
    pending_d  = pending_q + CntW'(comp_acc) - CntW'(ack_acc);
    doorbell_d = sub_acc;
    err_d      = err_q;
    // Index width equals log2 of the ring depth, so the increments wrap naturally.
    if (sub_acc) begin
      prod_d = prod_q + IDX_W'(1);
    end
    if (ack_acc) begin
      cons_d = cons_q + IDX_W'(1);
    end
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (comp_doorbell && (inflight_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q     <= '0;
      cons_q     <= '0;
      inflight_q <= '0;
      pending_q  <= '0;
      doorbell_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      cons_q     <= cons_d;
      inflight_q <= inflight_d;
      pending_q  <= pending_d;
      doorbell_q <= doorbell_d;
      err_q      <= err_d;
    end
  end

`ifdef CAI_SUBMIT_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((inflight_q == '0) || comp_acc) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TmoW'(TIMEOUT_CYCLES)) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
    timeout_d = timeout_q;
    if (err_clr) begin
      timeout_d = 1'b0;
    end
    // Counter saturates at the limit, so the flag re-asserts while the stall persists.
    if (tmo_cnt_d == TmoW'(TIMEOUT_CYCLES)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  assign slot_idx         = prod_q;
  assign comp_idx         = cons_q;
  assign comp_valid       = (pending_q != '0);
  assign inflight         = inflight_q;
  assign pending          = pending_q;
  assign submit_doorbell  = doorbell_q;
  assign err_spurious     = err_q;
  assign submit_ring_mask = 32'(RING_ENTRIES - 1);

endmodule

// File: tb/tb_cai_submit_tracker.sv
module tb_cai_submit_tracker;

  localparam int RING  = 8;
  localparam int IDX_W = 3;
  localparam int TMO   = 16;

  logic             clk;
  logic             rst;
  logic [IDX_W-1:0] slot_idx;
  logic             submit_valid;
  logic             submit_ready;
  logic             submit_doorbell;
  logic [31:0]      submit_ring_mask;
  logic             comp_doorbell;
  logic             comp_valid;
  logic [IDX_W-1:0] comp_idx;
  logic             comp_ack;
  logic [IDX_W:0]   inflight;
  logic [IDX_W:0]   pending;
  logic             err_spurious;
  logic             timeout;
  logic             err_clr;

  cai_submit_tracker #(
    .RING_ENTRIES  (RING),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .slot_idx        (slot_idx),
    .submit_valid    (submit_valid),
    .submit_ready    (submit_ready),
    .submit_doorbell (submit_doorbell),
    .submit_ring_mask(submit_ring_mask),
    .comp_doorbell   (comp_doorbell),
    .comp_valid      (comp_valid),
    .comp_idx        (comp_idx),
    .comp_ack        (comp_ack),
    .inflight        (inflight),
    .pending         (pending),
    .err_spurious    (err_spurious),
    .timeout         (timeout),
    .err_clr         (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model and scoreboard of submitted slot indices awaiting ack.
  int m_infl, m_pend, m_prod, m_cons, m_db, m_err;
  int sb[$];

  task automatic model_reset();
    m_infl = 0; m_pend = 0; m_prod = 0; m_cons = 0; m_db = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; submit_valid = 0; comp_doorbell = 0; comp_ack = 0; err_clr = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock with the given inputs; model updated, ack index checked against scoreboard.
  task automatic cycle(input logic sv, input logic cd, input logic ca, input logic ec);
    int s_acc, c_acc, a_acc, exp_idx, obs_idx;
    submit_valid = sv; comp_doorbell = cd; comp_ack = ca; err_clr = ec;
    s_acc = (sv && (m_infl + m_pend != RING)) ? 1 : 0;
    c_acc = (cd && m_infl != 0) ? 1 : 0;
    a_acc = (ca && m_pend != 0) ? 1 : 0;
    obs_idx = int'(comp_idx);
    @(posedge clk);
    if (s_acc != 0) begin
      sb.push_back(m_prod);
      m_prod = (m_prod + 1) % RING;
    end
    if (a_acc != 0) begin
      exp_idx = sb.pop_front();
      n_cmp++;
      if (obs_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL ack_comp_idx: got %0d expected %0d", obs_idx, exp_idx);
      end
      m_cons = (m_cons + 1) % RING;
    end
    if (ec) m_err = 0;
    if (cd && m_infl == 0) m_err = 1;
    m_infl = m_infl + s_acc - c_acc;
    m_pend = m_pend + c_acc - a_acc;
    m_db   = s_acc;
    #1;
    submit_valid = 0; comp_doorbell = 0; comp_ack = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 8;
    if (slot_idx !== 0) begin n_fail++; $display("FAIL rst_slot: got %0d expected 0", slot_idx); end
    if (submit_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", submit_ready); end
    if (comp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cvalid: got %b expected 0", comp_valid); end
    if (inflight !== 0) begin n_fail++; $display("FAIL rst_infl: got %0d expected 0", inflight); end
    if (pending !== 0) begin n_fail++; $display("FAIL rst_pend: got %0d expected 0", pending); end
    if (submit_doorbell !== 1'b0) begin n_fail++; $display("FAIL rst_db: got %b expected 0", submit_doorbell); end
    if (err_spurious !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags: got %b%b expected 00", err_spurious, timeout);
    end
    if (submit_ring_mask !== 32'd7) begin n_fail++; $display("FAIL rst_mask: got %0d expected 7", submit_ring_mask); end
  endtask

  task automatic test_single();
    do_reset();
    cycle(1, 0, 0, 0);
    n_cmp += 3;
    if (submit_doorbell !== 1'b1) begin n_fail++; $display("FAIL single_db: got %b expected 1", submit_doorbell); end
    if (slot_idx !== 1) begin n_fail++; $display("FAIL single_slot: got %0d expected 1", slot_idx); end
    if (inflight !== 1) begin n_fail++; $display("FAIL single_infl: got %0d expected 1", inflight); end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (submit_doorbell !== 1'b0) begin n_fail++; $display("FAIL single_db_drop: got %b expected 0", submit_doorbell); end
    cycle(0, 1, 0, 0);
    n_cmp += 3;
    if (comp_valid !== 1'b1) begin n_fail++; $display("FAIL single_cvalid: got %b expected 1", comp_valid); end
    if (comp_idx !== 0) begin n_fail++; $display("FAIL single_cidx: got %0d expected 0", comp_idx); end
    if (inflight !== 0) begin n_fail++; $display("FAIL single_infl0: got %0d expected 0", inflight); end
    cycle(0, 0, 1, 0);
    n_cmp += 2;
    if (pending !== 0) begin n_fail++; $display("FAIL single_pend: got %0d expected 0", pending); end
    if (comp_idx !== 1) begin n_fail++; $display("FAIL single_cidx1: got %0d expected 1", comp_idx); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < RING; i++) begin
      cycle(1, 0, 0, 0);
      n_cmp++;
      if (submit_doorbell !== 1'b1) begin n_fail++; $display("FAIL full_db%0d: got %b expected 1", i, submit_doorbell); end
    end
    n_cmp += 3;
    if (submit_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", submit_ready); end
    if (slot_idx !== 0) begin n_fail++; $display("FAIL full_slot: got %0d expected 0", slot_idx); end
    if (inflight !== 8) begin n_fail++; $display("FAIL full_infl: got %0d expected 8", inflight); end
    cycle(1, 0, 0, 0);
    n_cmp++;
    if (submit_doorbell !== 1'b0) begin n_fail++; $display("FAIL full_9th_db: got %b expected 0", submit_doorbell); end
    cycle(0, 1, 0, 0);
    n_cmp++;
    if (submit_ready !== 1'b0) begin n_fail++; $display("FAIL full_after_comp: got %b expected 0", submit_ready); end
    // Submit offered in the ack cycle must not be taken: the slot opens a cycle later.
    cycle(1, 0, 1, 0);
    n_cmp += 3;
    if (submit_doorbell !== 1'b0) begin n_fail++; $display("FAIL full_ack_db: got %b expected 0", submit_doorbell); end
    if (submit_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_again: got %b expected 1", submit_ready); end
    if (inflight !== 7) begin n_fail++; $display("FAIL full_infl7: got %0d expected 7", inflight); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    n_cmp += 3;
    if (inflight !== 3) begin n_fail++; $display("FAIL b2b_infl: got %0d expected 3", inflight); end
    if (pending !== 1) begin n_fail++; $display("FAIL b2b_pend: got %0d expected 1", pending); end
    if (submit_doorbell !== 1'b1) begin n_fail++; $display("FAIL b2b_db: got %b expected 1", submit_doorbell); end
    cycle(0, 1, 1, 0);
    n_cmp += 3;
    if (pending !== 1) begin n_fail++; $display("FAIL b2b_pend_keep: got %0d expected 1", pending); end
    if (inflight !== 2) begin n_fail++; $display("FAIL b2b_infl2: got %0d expected 2", inflight); end
    if (comp_idx !== 1) begin n_fail++; $display("FAIL b2b_cidx: got %0d expected 1", comp_idx); end
  endtask

  task automatic test_spurious();
    do_reset();
    cycle(0, 1, 0, 0);
    n_cmp += 4;
    if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set: got %b expected 1", err_spurious); end
    if (inflight !== 0) begin n_fail++; $display("FAIL spur_infl: got %0d expected 0", inflight); end
    if (pending !== 0) begin n_fail++; $display("FAIL spur_pend: got %0d expected 0", pending); end
    if (comp_valid !== 1'b0) begin n_fail++; $display("FAIL spur_cvalid: got %b expected 0", comp_valid); end
    cycle(0, 0, 0, 1);
    n_cmp++;
    if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_clr: got %b expected 0", err_spurious); end
    cycle(0, 1, 0, 1);
    n_cmp++;
    if (err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_set_wins: got %b expected 1", err_spurious); end
    cycle(0, 0, 1, 1);
    n_cmp += 2;
    if (comp_idx !== 0) begin n_fail++; $display("FAIL spur_ack_ignored: got %0d expected 0", comp_idx); end
    if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_clr2: got %b expected 0", err_spurious); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    n_cmp += 2;
    if (inflight !== 5) begin n_fail++; $display("FAIL mid_pre_infl: got %0d expected 5", inflight); end
    if (pending !== 2) begin n_fail++; $display("FAIL mid_pre_pend: got %0d expected 2", pending); end
    rst = 1'b1; submit_valid = 1'b1; comp_doorbell = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; submit_valid = 1'b0; comp_doorbell = 1'b0;
    model_reset();
    n_cmp += 6;
    if (inflight !== 0) begin n_fail++; $display("FAIL mid_infl: got %0d expected 0", inflight); end
    if (pending !== 0) begin n_fail++; $display("FAIL mid_pend: got %0d expected 0", pending); end
    if (slot_idx !== 0 || comp_idx !== 0) begin
      n_fail++; $display("FAIL mid_idx: got %0d/%0d expected 0/0", slot_idx, comp_idx);
    end
    if (submit_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", submit_ready); end
    if (submit_doorbell !== 1'b0) begin n_fail++; $display("FAIL mid_db: got %b expected 0", submit_doorbell); end
    if (err_spurious !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b expected 0", err_spurious); end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (submit_doorbell !== 1'b0) begin n_fail++; $display("FAIL mid_db_after: got %b expected 0", submit_doorbell); end
  endtask

  task automatic test_timeout();
    do_reset();
    cycle(1, 0, 0, 0);
`ifdef CAI_SUBMIT_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) cycle(0, 0, 0, 0);
    n_cmp++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", timeout); end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: got %b expected 1", timeout); end
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    n_cmp++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_quiet: got %b expected 0", timeout); end
`else
    for (int i = 0; i < TMO + 4; i++) cycle(0, 0, 0, 0);
    n_cmp++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_disabled: got %b expected 0", timeout); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
      n_cmp++;
      if (inflight !== m_infl || pending !== m_pend || slot_idx !== m_prod ||
          comp_idx !== m_cons || submit_doorbell !== m_db[0] ||
          err_spurious !== m_err[0] || comp_valid !== (m_pend != 0) ||
          submit_ready !== (m_infl + m_pend != RING)) begin
        n_fail++;
        $display("FAIL rand_state%0d: got infl=%0d pend=%0d slot=%0d cidx=%0d db=%b err=%b expected %0d %0d %0d %0d %0d %0d",
                 i, inflight, pending, slot_idx, comp_idx, submit_doorbell, err_spurious,
                 m_infl, m_pend, m_prod, m_cons, m_db, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1; submit_valid = 0; comp_doorbell = 0; comp_ack = 0; err_clr = 0;
    model_reset();
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
